// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: latches one vector instruction, drives the per-lane
// ALU one element per cycle, packs results into a destination image and
// hands the image to writeback.
// Optional feature macro: VECTOR_MASK_UNDISTURBED_EN (masked-off elements keep
// vd_old instead of capturing the ALU output).
// Writeback handshake: wb_valid rises when the image is complete; wb_data and
// wb_valid hold steady until a cycle with wb_valid && wb_ready, which is the
// transfer cycle; the block returns to IDLE at the end of that cycle.
module vector_lane_sequencer #(
  parameter int VLEN        = 256,
  parameter int VL_WIDTH    = 6,
  parameter int LEN         = 32,
  parameter int LONGEST_LEN = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VL_WIDTH-1:0]    vl,
  input  logic [2:0]             vsew,
  input  logic [2:0]             dest_vsew,
  input  logic                   vm,
  input  logic [5:0]             opcode,
  input  logic [2:0]             alu_signal,
  input  logic [1:0]             vec_operand_type,
  input  logic                   is_mask_operation,
  input  logic                   mask_is_operand,
  input  logic [LEN-1:0]         imm,
  input  logic [LEN-1:0]         rs,
  input  logic [VLEN-1:0]        vs1_data,
  input  logic [VLEN-1:0]        vs2_data,
  input  logic [VLEN-1:0]        v0_mask,
  input  logic [VLEN-1:0]        vd_old,
  output logic [LONGEST_LEN-1:0] alu_vs1,
  output logic [LONGEST_LEN-1:0] alu_vs2,
  output logic                   alu_mask,
  output logic                   alu_vm,
  output logic [2:0]             alu_prev_vsew,
  output logic [2:0]             alu_cur_vsew,
  output logic [5:0]             alu_opcode,
  output logic [2:0]             alu_signal_o,
  output logic [1:0]             alu_operand_type,
  output logic                   alu_is_mask_operation,
  output logic [LEN-1:0]         alu_imm,
  output logic [LEN-1:0]         alu_rs,
  input  logic [LONGEST_LEN-1:0] alu_result,
  output logic                   busy,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [VLEN-1:0]        wb_data,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [VL_WIDTH-1:0]   vl_r, idx;
  logic [2:0]            vsew_r, dvsew_r, signal_r;
  logic                  vm_r, is_mask_r, mask_op_r;
  logic [5:0]            opcode_r;
  logic [1:0]            optype_r;
  logic [LEN-1:0]        imm_r, rs_r;
  logic [VLEN-1:0]       vs1_r, vs2_r, v0_r, dst_q;

  logic                  accept, issue, last_elem, elem_active, mask_bit;
  logic [31:0]           src_bits, dst_bits, rd_off, wr_off;
  logic [LONGEST_LEN-1:0] src_mask, dst_mask, vs1_elem, vs2_elem, rs_ext, imm_ext;
  logic [VLEN-1:0]       vs1_sh, vs2_sh, v0_sh, wr_mask, wr_data, bit_sel;

  // SEW code to element width; unused codes fall back to bytes.
  function automatic logic [31:0] sew_bits(input logic [2:0] s);
    case (s)
      3'b001:  sew_bits = 32'd16;
      3'b010:  sew_bits = 32'd32;
      3'b011:  sew_bits = 32'd64;
      default: sew_bits = 32'd8;
    endcase
  endfunction

  function automatic logic [LONGEST_LEN-1:0] width_mask(input logic [31:0] b);
    width_mask = (b >= 32'(LONGEST_LEN)) ? '1 : ((LONGEST_LEN'(1) << b) - LONGEST_LEN'(1));
  endfunction

  assign accept    = (state_q == S_IDLE) && start;
  assign issue     = (state_q == S_ISSUE);
  assign last_elem = (idx == (vl_r - VL_WIDTH'(1)));
  assign dbg_state = state_q;
  assign wb_data   = dst_q;

  // Element extraction: shifting out of range yields zero, so oversized slices drop.
  always_comb begin
    src_bits = sew_bits(vsew_r);
    dst_bits = sew_bits(dvsew_r);
    src_mask = width_mask(src_bits);
    dst_mask = width_mask(dst_bits);
    rd_off   = 32'(idx) * src_bits;
    wr_off   = 32'(idx) * dst_bits;
    vs1_sh   = vs1_r >> rd_off;
    vs2_sh   = vs2_r >> rd_off;
    v0_sh    = v0_r >> idx;
    mask_bit = v0_sh[0];
    vs1_elem = vs1_sh[LONGEST_LEN-1:0] & src_mask;
    vs2_elem = vs2_sh[LONGEST_LEN-1:0] & src_mask;
    rs_ext   = {{(LONGEST_LEN-LEN){rs_r[LEN-1]}}, rs_r} & src_mask;
    imm_ext  = {{(LONGEST_LEN-LEN){imm_r[LEN-1]}}, imm_r} & src_mask;
    wr_mask  = {{(VLEN-LONGEST_LEN){1'b0}}, dst_mask} << wr_off;
    wr_data  = {{(VLEN-LONGEST_LEN){1'b0}}, alu_result & dst_mask} << wr_off;
    bit_sel  = VLEN'(1) << idx;
`ifdef VECTOR_MASK_UNDISTURBED_EN
    elem_active = vm_r | mask_bit | mask_op_r;
`else
    elem_active = 1'b1;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (vl == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (last_elem) state_d = S_DONE;
      S_DONE:  if (wb_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ALU controls are only driven while issuing, zero otherwise.
  always_comb begin
    busy                  = (state_q != S_IDLE);
    wb_valid              = (state_q == S_DONE);
    alu_vs1               = '0;
    alu_vs2               = '0;
    alu_mask              = 1'b0;
    alu_vm                = 1'b0;
    alu_prev_vsew         = '0;
    alu_cur_vsew          = '0;
    alu_opcode            = '0;
    alu_signal_o          = '0;
    alu_operand_type      = '0;
    alu_is_mask_operation = 1'b0;
    alu_imm               = '0;
    alu_rs                = '0;
    if (issue) begin
      case (optype_r)
        2'b01:   alu_vs1 = rs_ext;
        2'b10:   alu_vs1 = imm_ext;
        default: alu_vs1 = vs1_elem;
      endcase
      alu_vs2               = vs2_elem;
      alu_mask              = mask_bit;
      alu_vm                = vm_r;
      alu_prev_vsew         = vsew_r;
      alu_cur_vsew          = dvsew_r;
      alu_opcode            = opcode_r;
      alu_signal_o          = signal_r;
      alu_operand_type      = optype_r;
      alu_is_mask_operation = is_mask_r;
      alu_imm               = imm_r;
      alu_rs                = rs_r;
    end
  end

  // Datapath: latch the instruction on accept, step idx and capture results while issuing.
  always_ff @(posedge clk) begin
    if (rst) begin
      vl_r <= '0; idx <= '0; vsew_r <= '0; dvsew_r <= '0; signal_r <= '0;
      vm_r <= 1'b0; is_mask_r <= 1'b0; mask_op_r <= 1'b0; opcode_r <= '0;
      optype_r <= '0; imm_r <= '0; rs_r <= '0;
      vs1_r <= '0; vs2_r <= '0; v0_r <= '0; dst_q <= '0;
    end else if (accept) begin
      vl_r <= vl; idx <= '0; vsew_r <= vsew; dvsew_r <= dest_vsew;
      signal_r <= alu_signal; vm_r <= vm; is_mask_r <= is_mask_operation;
      mask_op_r <= mask_is_operand; opcode_r <= opcode; optype_r <= vec_operand_type;
      imm_r <= imm; rs_r <= rs;
      vs1_r <= vs1_data; vs2_r <= vs2_data; v0_r <= v0_mask; dst_q <= vd_old;
    end else if (issue) begin
      idx <= last_elem ? '0 : idx + VL_WIDTH'(1);
      if (elem_active) begin
        if (is_mask_r) begin
          if (32'(idx) < 32'(VLEN))
            dst_q <= (dst_q & ~bit_sel) | (alu_result[0] ? bit_sel : '0);
        end else if ((wr_off + dst_bits) <= 32'(VLEN)) begin
          dst_q <= (dst_q & ~wr_mask) | wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed testbench for vector_lane_sequencer. The bench plays the ALU:
// opcode 0 = add, 1 = sub (vs2 - vs1), 2 = madc (carry out at source SEW).
module tb_vector_lane_sequencer;
  localparam int VLEN = 256, VL_WIDTH = 6, LEN = 32, LL = 64;
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_MADC = 6'd2;

  logic clk = 1'b0, rst;
  logic start, vm, is_mask_operation, mask_is_operand, wb_ready;
  logic [VL_WIDTH-1:0] vl;
  logic [2:0] vsew, dest_vsew, alu_signal;
  logic [5:0] opcode;
  logic [1:0] vec_operand_type;
  logic [LEN-1:0] imm, rs;
  logic [VLEN-1:0] vs1_data, vs2_data, v0_mask, vd_old;
  logic [LL-1:0] alu_vs1, alu_vs2, alu_result;
  logic alu_mask, alu_vm, alu_is_mask_operation, busy, wb_valid;
  logic [2:0] alu_prev_vsew, alu_cur_vsew, alu_signal_o;
  logic [5:0] alu_opcode;
  logic [1:0] alu_operand_type, dbg_state;
  logic [LEN-1:0] alu_imm, alu_rs;
  logic [VLEN-1:0] wb_data;

  int n_cmp = 0;
  int n_fail = 0;

  vector_lane_sequencer #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH), .LEN(LEN), .LONGEST_LEN(LL)) dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl), .vsew(vsew), .dest_vsew(dest_vsew),
    .vm(vm), .opcode(opcode), .alu_signal(alu_signal), .vec_operand_type(vec_operand_type),
    .is_mask_operation(is_mask_operation), .mask_is_operand(mask_is_operand),
    .imm(imm), .rs(rs), .vs1_data(vs1_data), .vs2_data(vs2_data), .v0_mask(v0_mask),
    .vd_old(vd_old), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_mask(alu_mask),
    .alu_vm(alu_vm), .alu_prev_vsew(alu_prev_vsew), .alu_cur_vsew(alu_cur_vsew),
    .alu_opcode(alu_opcode), .alu_signal_o(alu_signal_o), .alu_operand_type(alu_operand_type),
    .alu_is_mask_operation(alu_is_mask_operation), .alu_imm(alu_imm), .alu_rs(alu_rs),
    .alu_result(alu_result), .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural ALU stand-in
  always_comb begin
    logic [64:0] sum;
    int sb;
    case (alu_prev_vsew)
      3'b001:  sb = 16;
      3'b010:  sb = 32;
      3'b011:  sb = 64;
      default: sb = 8;
    endcase
    sum = {1'b0, alu_vs1} + {1'b0, alu_vs2} + {64'd0, (!alu_vm && alu_mask)};
    alu_result = '0;
    case (alu_opcode)
      OP_ADD:  alu_result = alu_vs1 + alu_vs2;
      OP_SUB:  alu_result = alu_vs2 - alu_vs1;
      OP_MADC: alu_result = {63'd0, sum[sb]};
      default: alu_result = '0;
    endcase
    if (!alu_vm && !alu_mask && !alu_is_mask_operation) alu_result = '0;
  end

  task automatic set_defaults();
    start = 0; vl = '0; vsew = 3'b000; dest_vsew = 3'b000; vm = 1; opcode = OP_ADD;
    alu_signal = 3'd0; vec_operand_type = 2'b00; is_mask_operation = 0;
    mask_is_operand = 0; imm = '0; rs = '0; vs1_data = '0; vs2_data = '0;
    v0_mask = '0; vd_old = '0; wb_ready = 0;
  endtask

  // Accept edge is cycle 0; returns 1ns into cycle 1.
  task automatic do_start(input logic [VL_WIDTH-1:0] n);
    vl = n;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  // Count cycles until wb_valid; ends at the negedge of the first DONE cycle.
  task automatic wait_wb(input int cyc0, input int exp_cyc, input string nm);
    int cyc;
    bit seen;
    cyc = cyc0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      cyc++;
      if (wb_valid === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s_latency: got cycle %0d (seen=%0b), expected cycle %0d", nm, cyc, seen, exp_cyc);
    end
  endtask

  task automatic check_data(input string nm, input logic [VLEN-1:0] exp);
    n_cmp++;
    if (wb_data !== exp) begin
      n_fail++;
      $display("FAIL %s_data: got %h expected %h", nm, wb_data, exp);
    end
  endtask

  task automatic release_wb();
    wb_ready = 1;
    @(posedge clk);
    #1 wb_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    n_cmp++; if (wb_data !== '0) begin n_fail++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
    n_cmp++; if (alu_vs1 !== '0 || alu_vs2 !== '0) begin n_fail++; $display("FAIL reset_alu_vs: got %h/%h expected 0/0", alu_vs1, alu_vs2); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    #1 rst = 0;
  endtask

  task automatic test_vv_add();
    set_defaults();
    vs1_data = 256'h04030201; vs2_data = 256'h281E140A; vd_old = '1;
    do_start(6'd4);
    wait_wb(0, 5, "vv_add");
    check_data("vv_add", {{224{1'b1}}, 32'h2C21160B});
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vv_add_busy: got %b expected 1", busy); end
    release_wb();
  endtask

  task automatic test_vx_sub();
    set_defaults();
    vsew = 3'b010; dest_vsew = 3'b010; vec_operand_type = 2'b01; opcode = OP_SUB;
    rs = 32'hFFFFFFFF; vs1_data = 256'h1234; vs2_data = {192'd0, 32'd7, 32'd5};
    do_start(6'd2);
    @(negedge clk);
    n_cmp++; if (alu_vs1 !== 64'h00000000FFFFFFFF) begin n_fail++; $display("FAIL vx_alu_vs1: got %h expected 00000000ffffffff", alu_vs1); end
    n_cmp++; if (alu_vs2 !== 64'd5) begin n_fail++; $display("FAIL vx_alu_vs2_e0: got %h expected 5", alu_vs2); end
    @(negedge clk);
    n_cmp++; if (alu_vs2 !== 64'd7) begin n_fail++; $display("FAIL vx_alu_vs2_e1: got %h expected 7", alu_vs2); end
    wait_wb(2, 3, "vx_sub");
    check_data("vx_sub", {192'd0, 32'd8, 32'd6});
    release_wb();
  endtask

  task automatic test_masked();
    logic [VLEN-1:0] exp;
    set_defaults();
    vm = 0; v0_mask = 256'b0101;
    vs1_data = 256'h04030201; vs2_data = 256'h281E140A;
    vd_old = {32{8'hAA}};
`ifdef VECTOR_MASK_UNDISTURBED_EN
    exp = {{28{8'hAA}}, 32'hAA21AA0B};
`else
    exp = {{28{8'hAA}}, 32'h0021000B};
`endif
    do_start(6'd4);
    wait_wb(0, 5, "masked");
    check_data("masked", exp);
    release_wb();
  endtask

  task automatic test_madc();
    set_defaults();
    opcode = OP_MADC; is_mask_operation = 1; mask_is_operand = 1;
    vs1_data = 256'hFF0180; vs2_data = 256'h010180; vd_old = '0;
    do_start(6'd3);
    wait_wb(0, 4, "madc");
    check_data("madc", 256'h5);
    release_wb();
  endtask

  task automatic test_vl_zero();
    logic [VLEN-1:0] pat;
    set_defaults();
    pat = {8{32'hDEADBEEF}};
    vd_old = pat;
    do_start(6'd0);
    vd_old = '0;
    wait_wb(0, 1, "vl0");
    check_data("vl0", pat);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL vl0_hold_valid: got %b expected 1", wb_valid); end
      check_data("vl0_hold", pat);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vl0_hold_busy: got %b expected 1", busy); end
    end
    release_wb();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vl0_after_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    set_defaults();
    vs1_data = {32{8'h01}}; vs2_data = {32{8'h02}}; vd_old = '1;
    do_start(6'd8);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wb_valid: got %b expected 0", wb_valid); end
    check_data("rst_mid", '0);
    n_cmp++; if (alu_vs2 !== '0) begin n_fail++; $display("FAIL rst_mid_alu_vs2: got %h expected 0", alu_vs2); end
    vs1_data = 256'h11; vs2_data = 256'h22;
    do_start(6'd1);
    wait_wb(0, 2, "restart");
    check_data("restart", {{248{1'b1}}, 8'h33});
    release_wb();
  endtask

  task automatic test_back_to_back();
    set_defaults();
    wb_ready = 1;
    vs1_data = 256'h05; vs2_data = 256'h06;
    do_start(6'd1);
    wait_wb(0, 2, "b2b_first");
    check_data("b2b_first", 256'h0B);
    @(negedge clk);
    n_cmp++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got valid=%b busy=%b expected 0/0", wb_valid, busy); end
    vs1_data = 256'h10; vs2_data = 256'h20;
    do_start(6'd1);
    wait_wb(0, 2, "b2b_second");
    check_data("b2b_second", 256'h30);
    wb_ready = 0;
    @(negedge clk);
  endtask

  initial begin
    set_defaults();
    rst = 1;
    test_reset();
    test_vv_add();
    test_vx_sub();
    test_masked();
    test_madc();
    test_vl_zero();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
# vector_lane_sequencer

Multi-cycle element sequencer sitting directly upstream of the per-lane vector ALU. It latches one whole vector instruction's operands, drives the combinational ALU one element per cycle, substitutes scalar or immediate operands, and selects mask bits. It captures each ALU result, packs it into a destination register image with tail and mask policy applied, and hands the image to writeback over a valid/ready handshake.

## Interface
- `VLEN`, 256: vector register width in bits.
- `VL_WIDTH`, 6: width of `vl`; holds 0..VLEN/8.
- `LEN`, 32: scalar and immediate width.
- `LONGEST_LEN`, 64: ALU operand and result width.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  accepts an instruction when in IDLE.
- `vl`, `vsew`, `dest_vsew`, `vm`, `opcode[5:0]`, `alu_signal[2:0]`, `vec_operand_type[1:0]`, `is_mask_operation`, `mask_is_operand`  in  instruction fields, all captured on `start`.
- `imm`, `rs`  in  LEN  sign-extended scalar operands.
- `vs1_data`, `vs2_data`, `v0_mask`, `vd_old`  in  VLEN  source registers, v0, and the previous destination.
- `alu_vs1`, `alu_vs2`  out  64  current element, zero-padded.
- `alu_mask`, `alu_vm`, `alu_prev_vsew`, `alu_cur_vsew`, `alu_opcode`, `alu_signal_o`, `alu_operand_type`, `alu_is_mask_operation`, `alu_imm`, `alu_rs`  out  ALU controls.
- `alu_result`  in  64  combinational ALU output.
- `busy`  out  1  high from the cycle after accept until writeback is accepted.
- `wb_valid`  out  1  packed image ready.
- `wb_ready`  in  1  writeback accepts.
- `wb_data`  out  VLEN  packed destination image.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- IDLE → ISSUE on `start` when `vl`≠0. IDLE → DONE on `start` when `vl`=0.
- ISSUE → DONE after element `vl`-1 is captured.
- DONE → IDLE when `wb_ready` is high.
- `start` outside IDLE is ignored.
- Element counter `idx` runs 0..vl-1.
- SEW encoding, taken from the shared defines: 000=8, 001=16, 010=32, 011=64 bits.
- Source element `i` is read from `vs*_data` bits [i*SEW +: SEW] at `vsew`.
- `alu_vs1` selection by `vec_operand_type`:
  - 00: vs1 element.
  - 01: `rs` truncated to SEW.
  - 10: `imm` truncated to SEW.
  - 11: treated as 00.
- `alu_mask` = `v0_mask[idx]`.
- `alu_prev_vsew` = `vsew`; `alu_cur_vsew` = `dest_vsew`.
- `buf` is initialised to `vd_old` on accept.
- Capture for element `idx`:
  - Mask ops write `buf[idx]` = `alu_result[0]`.
  - All other ops write `alu_result` truncated to dest SEW at `buf[idx*DSEW +: DSEW]`.
- An element whose slice would exceed VLEN is dropped, not wrapped.
- Tail elements (idx ≥ vl) are never written; they stay at `vd_old`.
- `wb_data` = `buf`.

## Timing
- Reset values: IDLE, `busy`=0, `wb_valid`=0, `wb_data`=0, `idx`=0, all `alu_*` outputs 0.
- `start` sampled high at edge 0 → element `i` is driven during cycle 1+i and captured at the end of that cycle.
- `wb_valid` rises in cycle vl+1, so latency is vl+1 cycles.
- `vl`=0: `wb_valid` is high in cycle 1 with `wb_data`=`vd_old`.
- `wb_valid` and `wb_data` hold steady until `wb_ready`.
- `wb_ready` already high on the first DONE cycle gives a one-cycle DONE.
- A new `start` is accepted in the cycle after the return to IDLE.
- `rst` mid-operation aborts without a writeback, and all outputs return to reset values at that edge.

## Configuration
- `VECTOR_MASK_UNDISTURBED_EN` defined:
  - An element with `vm`=0, `v0_mask[idx]`=0 and `mask_is_operand`=0 is inactive.
  - Its capture is suppressed, so it keeps `vd_old`.
  - It still consumes one cycle.
- `VECTOR_MASK_UNDISTURBED_EN` undefined: every element captures the ALU output, which is 0 for masked-off elements.
- `mask_is_operand`=1 (adc/sbc/madc family) always captures, in both builds.

## Test plan
- vv add, vsew=dest=000, vl=4, vm=1, vs1 bytes {1,2,3,4}, vs2 {10,20,30,40}, vd_old all 0xFF → wb_valid in cycle 5, low bytes {11,22,33,44}, bytes 4..31 stay 0xFF.
- vx sub, SEW32, vl=2, rs=0xFFFFFFFF, vs2 {5,7} → `alu_vs1`=0x00000000FFFFFFFF, results {6,8}.
- Masked add, vm=0, v0=0b0101, vl=4, byte SEW, vd_old=0xAA:
  - With the macro: bytes {r0,0xAA,r2,0xAA}.
  - Without the macro: {r0,0x00,r2,0x00}.
- madc, is_mask_operation=1, vl=3, vs1/vs2 bytes {0x80/0x80, 0x01/0x01, 0xFF/0x01}, vd_old=0 → wb_data[2:0]=3'b101.
- vl=0 → wb_valid in cycle 1 with wb_data=vd_old; hold wb_ready=0 for 3 cycles → data stable, busy=1.
- rst asserted during element 2 of vl=8 → next cycle busy=0, wb_valid=0. Re-start with vl=1 → wb_valid in cycle 2.
